// File: rtl/mbus_ice_driver_tx_multi.sv
// rtl/mbus_ice_driver_tx_multi.sv - byte stream to MBus multi-word transmit engine (optional watchdog: MBUS_TX_WATCHDOG_EN)
module mbus_ice_driver_tx_multi #(
  parameter int DATA_BYTES  = 4,
  parameter int MAX_WORDS   = 64,
  parameter int TIMEOUT_CYC = 65535,
  parameter int WC_W        = $clog2(MAX_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_frame_valid,
  input  logic                    tx_char_valid,
  input  logic [7:0]              tx_char,
  input  logic                    tx_char_pending,
  output logic                    tx_char_advance,
  output logic [31:0]             tx_mbus_txaddr,
  output logic [8*DATA_BYTES-1:0] tx_mbus_txdata,
  output logic                    tx_mbus_txreq,
  output logic                    tx_mbus_txpend,
  input  logic                    tx_mbus_txack,
  input  logic                    tx_mbus_txsucc,
  input  logic                    tx_mbus_txfail,
  output logic                    tx_mbus_txresp_ack,
  output logic                    tx_gen_ack,
  output logic                    tx_gen_nak,
  input  logic                    tx_acknak_valid,
  output logic                    tx_busy,
  output logic [WC_W-1:0]         tx_word_count
);

  localparam int TXD_W = 8 * DATA_BYTES;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    DATA   = 4'd2,
    WAIT   = 4'd3,
    TXREQ  = 4'd4,
    TXACK  = 4'd5,
    DRAIN  = 4'd6,
    TXSUCC = 4'd7,
    RESULT = 4'd8
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] byte_cnt;
  logic       overflow;
  logic       at_limit;
  logic       addr_last;
  logic       data_last;
  logic       wd_expired;

  // Word counter has reached the per-message limit (counted after the ack).
  assign at_limit  = (tx_word_count == WC_W'(MAX_WORDS));
  // First address byte with a non-F high nibble is a complete short address.
  assign addr_last = (byte_cnt == 2'd0) ? (tx_char[7:4] != 4'hF) : (byte_cnt == 2'd3);
  assign data_last = (byte_cnt == 2'(DATA_BYTES - 1));

`ifdef MBUS_TX_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_cnt;

  // Handshake watchdog: restarts on every state change, counts while waiting on the master.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_next != state) begin
      wd_cnt <= '0;
    end else if (state == TXREQ || state == TXSUCC) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a handshake always wins over a watchdog expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (tx_frame_valid) state_next = ADDR;
      ADDR:   if (tx_char_valid && addr_last) state_next = DATA;
      DATA:   if (tx_char_valid && data_last) state_next = WAIT;
      WAIT:   state_next = TXREQ;
      TXREQ: begin
        if (tx_mbus_txack)   state_next = TXACK;
        else if (wd_expired) state_next = RESULT;
      end
      TXACK: begin
        if (!tx_mbus_txack) begin
          if (tx_char_pending && !at_limit) state_next = DATA;
          else if (tx_char_pending)         state_next = DRAIN;
          else                              state_next = TXSUCC;
        end
      end
      DRAIN:  if (!tx_char_pending && !tx_char_valid) state_next = TXSUCC;
      TXSUCC: if (tx_mbus_txsucc || tx_mbus_txfail || wd_expired) state_next = RESULT;
      RESULT: if (!tx_acknak_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode, including the Mealy ack/nak pulses on the exit from TXSUCC/TXREQ.
  always_comb begin
    tx_char_advance    = 1'b0;
    tx_mbus_txreq      = 1'b0;
    tx_mbus_txpend     = 1'b0;
    tx_mbus_txresp_ack = 1'b0;
    tx_gen_ack         = 1'b0;
    tx_gen_nak         = 1'b0;
    tx_busy            = (state != IDLE);
    case (state)
      ADDR, DATA, DRAIN: tx_char_advance = tx_char_valid;
      TXREQ: begin
        tx_mbus_txreq  = 1'b1;
        tx_mbus_txpend = tx_char_pending & (tx_word_count != WC_W'(MAX_WORDS - 1));
        if (!tx_mbus_txack && wd_expired) tx_gen_nak = 1'b1;
      end
      TXSUCC: begin
        if (tx_mbus_txfail)      tx_gen_nak = 1'b1;
        else if (tx_mbus_txsucc) begin
          tx_gen_ack = ~overflow;
          tx_gen_nak = overflow;
        end
        else if (wd_expired)     tx_gen_nak = 1'b1;
      end
      RESULT: tx_mbus_txresp_ack = 1'b1;
      default: ;
    endcase
  end

  // Address/data assembly, word counting and overflow tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_mbus_txaddr <= '0;
      tx_mbus_txdata <= '0;
      tx_word_count  <= '0;
      overflow       <= 1'b0;
      byte_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_frame_valid) begin
            tx_word_count <= '0;
            overflow      <= 1'b0;
            byte_cnt      <= '0;
          end
        end
        ADDR: begin
          if (tx_char_valid) begin
            if (byte_cnt == 2'd0) begin
              tx_mbus_txaddr <= {24'h0, tx_char};
            end else begin
              tx_mbus_txaddr <= {tx_mbus_txaddr[23:0], tx_char};
            end
            byte_cnt <= addr_last ? 2'd0 : byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (tx_char_valid) begin
            tx_mbus_txdata <= (tx_mbus_txdata << 8) | TXD_W'(tx_char);
            byte_cnt       <= data_last ? 2'd0 : byte_cnt + 2'd1;
          end
        end
        TXREQ: begin
          if (tx_mbus_txack) tx_word_count <= tx_word_count + WC_W'(1);
        end
        TXACK: begin
          if (!tx_mbus_txack && tx_char_pending && at_limit) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_ice_driver_tx_multi.sv
// tb/tb_mbus_ice_driver_tx_multi.sv - scoreboard bench for mbus_ice_driver_tx_multi
module tb_mbus_ice_driver_tx_multi;

  localparam int DB  = 4;
  localparam int MW  = 3;
  localparam int TO  = 16;
  localparam int WCW = $clog2(MW + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tx_frame_valid = 1'b0;
  logic           tx_char_valid = 1'b0;
  logic [7:0]     tx_char = 8'h00;
  logic           tx_char_pending = 1'b0;
  logic           tx_char_advance;
  logic [31:0]    tx_mbus_txaddr;
  logic [8*DB-1:0] tx_mbus_txdata;
  logic           tx_mbus_txreq;
  logic           tx_mbus_txpend;
  logic           tx_mbus_txack = 1'b0;
  logic           tx_mbus_txsucc = 1'b0;
  logic           tx_mbus_txfail = 1'b0;
  logic           tx_mbus_txresp_ack;
  logic           tx_gen_ack;
  logic           tx_gen_nak;
  logic           tx_acknak_valid = 1'b0;
  logic           tx_busy;
  logic [WCW-1:0] tx_word_count;

  mbus_ice_driver_tx_multi #(
    .DATA_BYTES(DB), .MAX_WORDS(MW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_frame_valid(tx_frame_valid), .tx_char_valid(tx_char_valid), .tx_char(tx_char),
    .tx_char_pending(tx_char_pending), .tx_char_advance(tx_char_advance),
    .tx_mbus_txaddr(tx_mbus_txaddr), .tx_mbus_txdata(tx_mbus_txdata),
    .tx_mbus_txreq(tx_mbus_txreq), .tx_mbus_txpend(tx_mbus_txpend),
    .tx_mbus_txack(tx_mbus_txack), .tx_mbus_txsucc(tx_mbus_txsucc), .tx_mbus_txfail(tx_mbus_txfail),
    .tx_mbus_txresp_ack(tx_mbus_txresp_ack), .tx_gen_ack(tx_gen_ack), .tx_gen_nak(tx_gen_nak),
    .tx_acknak_valid(tx_acknak_valid), .tx_busy(tx_busy), .tx_word_count(tx_word_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic pend; } req_t;
  typedef struct { logic nak; logic [WCW-1:0] wc; } res_t;

  req_t       exp_req[$];
  res_t       exp_res[$];
  logic [7:0] char_q[$];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         gap = 1;
  int         adv_cnt = 0;
  int         adv_total = 0;
  int         idle_cyc = 0;
  int         last_lat = 0;
  bit         resp_en = 1'b1;
  int         resp_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte source: presents the head of char_q, pops it once the DUT advanced it.
  initial begin
    logic       adv_seen;
    logic       present;
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      adv_seen = tx_char_valid && tx_char_advance;
      if (tx_char_advance) adv_total++;
      @(posedge clk);
      #1;
      if (adv_seen && char_q.size() > 0) begin
        tmp = char_q.pop_front();
        adv_cnt++;
      end
      present         = (char_q.size() > 0) && (cyc % gap == 0);
      tx_char_valid   = present;
      tx_char         = present ? char_q[0] : 8'h00;
      tx_char_pending = (char_q.size() > 1) || (char_q.size() == 1 && !present);
      tx_frame_valid  = (char_q.size() > 0);
    end
  end

  // MBus master model: one-cycle txack per request, result after the last word.
  initial begin
    logic last_pend;
    forever begin
      @(negedge clk);
      if (resp_en && tx_mbus_txreq && !tx_mbus_txack) begin
        last_pend = tx_mbus_txpend;
        @(posedge clk); #1 tx_mbus_txack = 1'b1;
        @(posedge clk); #1 tx_mbus_txack = 1'b0;
        if (!last_pend) begin
          tx_mbus_txsucc = (resp_mode == 0) || (resp_mode == 2);
          tx_mbus_txfail = (resp_mode != 0);
        end
      end
      if (tx_mbus_txresp_ack && (tx_mbus_txsucc || tx_mbus_txfail)) begin
        @(posedge clk); #1;
        tx_mbus_txsucc = 1'b0;
        tx_mbus_txfail = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new request and each ack/nak pulse.
  initial begin
    logic req_prev = 1'b0;
    req_t r;
    res_t s;
    forever begin
      @(negedge clk);
      if (!tx_busy) idle_cyc = cyc;
      if (tx_mbus_txreq && !req_prev) begin
        last_lat = cyc - idle_cyc;
        if (exp_req.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else begin
          r = exp_req.pop_front();
          check("req_addr", tx_mbus_txaddr, r.addr);
          check("req_data", tx_mbus_txdata, r.data);
          check("req_pend", tx_mbus_txpend, r.pend);
        end
      end
      req_prev = tx_mbus_txreq;
      if (tx_gen_ack || tx_gen_nak) begin
        check("acknak_excl", tx_gen_ack & tx_gen_nak, 0);
        if (exp_res.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          s = exp_res.pop_front();
          check("res_nak", tx_gen_nak, s.nak);
          check("res_wc", tx_word_count, s.wc);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    char_q.push_back(b);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) char_q.push_back(w[8*i +: 8]);
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [31:0] d, input logic p);
    req_t r;
    r.addr = a; r.data = d; r.pend = p;
    exp_req.push_back(r);
  endtask

  task automatic expect_res(input logic nak, input int wc);
    res_t r;
    r.nak = nak; r.wc = WCW'(wc);
    exp_res.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_data"}, {tx_mbus_txaddr, tx_mbus_txdata}, 64'h0);
    check({tag, "_flags"}, {tx_mbus_txreq, tx_mbus_txpend, tx_busy, tx_char_advance,
                            tx_gen_ack, tx_gen_nak, tx_mbus_txresp_ack, tx_word_count}, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((tx_busy || char_q.size() != 0 || exp_res.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, (n >= 3000), 0);
    check({tag, "_req_left"}, exp_req.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_msg();
    @(negedge clk);
    adv_cnt = 0;
    adv_total = 0;
  endtask

  initial begin
    int n;
    int hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Short address, one word, success.
    start_msg();
    expect_req(32'h0000_0014, 32'hDEAD_BEEF, 1'b0);
    expect_res(1'b0, 1);
    push_byte(8'h14); push_word(32'hDEAD_BEEF);
    wait_done("short");
    check("short_latency", last_lat, 7);
    check("short_adv", adv_total, 5);
    check("short_wc", tx_word_count, 1);

    // Long address, three words, fail.
    start_msg();
    resp_mode = 1;
    expect_req(32'hF012_3456, 32'h0102_0304, 1'b1);
    expect_req(32'hF012_3456, 32'hA5A5_A5A5, 1'b1);
    expect_req(32'hF012_3456, 32'hCAFE_F00D, 1'b0);
    expect_res(1'b1, 3);
    push_byte(8'hF0); push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
    push_word(32'h0102_0304); push_word(32'hA5A5_A5A5); push_word(32'hCAFE_F00D);
    wait_done("long");
    check("long_adv", adv_total, 16);

    // Five-word frame against a three-word limit: drain the rest, then nak despite txsucc.
    start_msg();
    resp_mode = 0;
    expect_req(32'h22, 32'h1111_1111, 1'b1);
    expect_req(32'h22, 32'h2222_2222, 1'b1);
    expect_req(32'h22, 32'h3333_3333, 1'b0);
    expect_res(1'b1, 3);
    push_byte(8'h22);
    push_word(32'h1111_1111); push_word(32'h2222_2222); push_word(32'h3333_3333);
    push_word(32'h4444_4444); push_word(32'h5555_5555);
    wait_done("ovf");
    check("ovf_adv", adv_cnt, 21);
    check("ovf_adv_total", adv_total, 21);

    // txsucc and txfail together: fail wins; RESULT holds while the ack/nak generator is busy.
    start_msg();
    resp_mode = 2;
    tx_acknak_valid = 1'b1;
    expect_req(32'h33, 32'h0BAD_F00D, 1'b0);
    expect_res(1'b1, 1);
    push_byte(8'h33); push_word(32'h0BAD_F00D);
    n = 0;
    while (!tx_gen_nak && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("both_hold", {tx_busy, tx_mbus_txresp_ack}, 2'b11);
    tx_acknak_valid = 1'b0;
    wait_done("both");
    resp_mode = 0;

    // Chars only every third cycle.
    start_msg();
    gap = 3;
    expect_req(32'h7E, 32'h1234_5678, 1'b0);
    expect_res(1'b0, 1);
    push_byte(8'h7E); push_word(32'h1234_5678);
    wait_done("slow");
    check("slow_adv", adv_cnt, 5);
    check("slow_adv_total", adv_total, 5);
    gap = 1;

    // Reset while in TXREQ, then a normal frame.
    start_msg();
    resp_en = 1'b0;
    expect_req(32'h40, 32'h0BAD_C0DE, 1'b0);
    push_byte(8'h40); push_word(32'h0BAD_C0DE);
    n = 0;
    while (!tx_mbus_txreq && n < 200) begin @(negedge clk); n++; end
    check("rst_req_seen", tx_mbus_txreq, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_txreq");
    reset = 1'b0;
    resp_en = 1'b1;
    start_msg();
    expect_req(32'h41, 32'h600D_F00D, 1'b0);
    expect_res(1'b0, 1);
    push_byte(8'h41); push_word(32'h600D_F00D);
    wait_done("after_rst");

    // Master never acks.
    start_msg();
    resp_en = 1'b0;
    expect_req(32'h55, 32'h0F1E_2D3C, 1'b0);
`ifdef MBUS_TX_WATCHDOG_EN
    expect_res(1'b1, 0);
`endif
    push_byte(8'h55); push_word(32'h0F1E_2D3C);
    n = 0;
    while (!tx_mbus_txreq && n < 200) begin @(negedge clk); n++; end
    check("wd_req_seen", tx_mbus_txreq, 1);
    hi = 0;
`ifdef MBUS_TX_WATCHDOG_EN
    while (tx_mbus_txreq && hi < 200) begin hi++; @(negedge clk); end
    check("wd_req_cycles", hi, TO);
    wait_done("wd");
`else
    while (tx_mbus_txreq && hi < 110) begin hi++; @(negedge clk); end
    check("nowd_req_held", hi, 110);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("nowd_rst");
`endif
    resp_en = 1'b1;

    check("res_left", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench time limit");
  end

endmodule
